atm_keypad_entry: RTL

ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

---
 rtl/atm_keypad_entry_pkg.sv | 32 +++
 rtl/atm_keypad_entry_if.sv | 33 +++
 rtl/atm_keypad_entry_digit_accumulator.sv | 42 ++++
 rtl/atm_keypad_entry.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_keypad_entry_pkg.sv
// Shared keypad/ATM definitions: key codes, FSM state encoding and operation codes.
// These values must stay identical to the ones the ATM block decodes.
package atm_keypad_entry_pkg;

    localparam int FIELD_W = 14;

    localparam logic [3:0] KEY_ENTER  = 4'd10;
    localparam logic [3:0] KEY_CLEAR  = 4'd11;
    localparam logic [3:0] KEY_CANCEL = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LANG   = 3'd1,
        ST_ACC    = 3'd2,
        ST_PIN    = 3'd3,
        ST_OP     = 3'd4,
        ST_NEWPIN = 3'd5,
        ST_AMOUNT = 3'd6,
        ST_SEND   = 3'd7
    } state_e;

    localparam logic [2:0] OP_NONE       = 3'd0;
    localparam logic [2:0] OP_BALANCE    = 3'd1;
    localparam logic [2:0] OP_WITHDRAW   = 3'd2;
    localparam logic [2:0] OP_DEPOSIT    = 3'd3;
    localparam logic [2:0] OP_CHANGE_PIN = 3'd4;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/atm_keypad_entry_if.sv
// Keypad-side and transaction-side signals of the ATM keypad entry block.
// master = keypad/ATM side, slave = the entry block itself.
interface atm_keypad_entry_if;
    import atm_keypad_entry_pkg::*;

    logic               key_valid;
    logic [3:0]         key_code;
    logic               txn_ready;
    logic               txn_valid;
    logic [3:0]         acc_num;
    logic [FIELD_W-1:0] pin;
    logic [FIELD_W-1:0] new_pin;
    logic [FIELD_W-1:0] amount;
    logic [2:0]         operation;
    logic               language;
    logic [2:0]         state;
    logic               busy;
    logic               error;
    logic               timeout;

    modport master (
        output key_valid, key_code, txn_ready,
        input  txn_valid, acc_num, pin, new_pin, amount, operation, language,
               state, busy, error, timeout
    );

    modport slave (
        input  key_valid, key_code, txn_ready,
        output txn_valid, acc_num, pin, new_pin, amount, operation, language,
               state, busy, error, timeout
    );

endinterface

// File: rtl/atm_keypad_entry_digit_accumulator.sv
// Decimal digit accumulator shared by the pin, new-pin and amount fields.
// Holds the running value and digit count; refuses digits once MAX_DIGITS are held.
module digit_accumulator #(
    parameter int MAX_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               digit_en,
    input  logic [3:0]         digit,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic [VALUE_W-1:0] next_value
);

    logic [VALUE_W-1:0] value_r;
    logic [CNT_W-1:0]   count_r;

    assign full       = (count_r == CNT_W'(MAX_DIGITS));
    assign next_value = (value_r * VALUE_W'(10)) + VALUE_W'(digit);
    assign count      = count_r;

    // Value/count register: clear wins over a new digit, full blocks further digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= {VALUE_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            value_r <= {VALUE_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (digit_en && !full) begin
            value_r <= next_value;
            count_r <= count_r + CNT_W'(1);
        end else begin
            value_r <= value_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// ATM keypad entry FSM: collects language, account, PIN, operation and amount/new PIN keys
// and presents them as one transaction. Optional abandon timer: define KEYPAD_TIMEOUT_EN.
module atm_keypad_entry
    import atm_keypad_entry_pkg::*;
#(
    parameter int MAX_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rst,
    atm_keypad_entry_if.slave kp
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_e             state_r;
    logic               lang_r;
    logic [3:0]         acc_num_r;
    logic               acc_loaded_r;
    logic [FIELD_W-1:0] pin_r;
    logic [FIELD_W-1:0] new_pin_r;
    logic [FIELD_W-1:0] amount_r;
    logic [2:0]         op_r;
    logic               txn_valid_r;
    logic               busy_r;
    logic               error_r;
    logic               timeout_r;

    logic               in_field_s;
    logic               acc_digit_s;
    logic               acc_clear_s;
    logic               go_idle_s;
    logic               timeout_hit_s;
    logic [CNT_W-1:0]   acc_count_s;
    logic               acc_full_s;
    logic [FIELD_W-1:0] acc_next_s;

    digit_accumulator #(
        .MAX_DIGITS (MAX_DIGITS),
        .VALUE_W    (FIELD_W),
        .CNT_W      (CNT_W)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear_s),
        .digit_en   (acc_digit_s),
        .digit      (kp.key_code),
        .count      (acc_count_s),
        .full       (acc_full_s),
        .next_value (acc_next_s)
    );

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             entry_active_s;

    assign entry_active_s = (state_r != ST_IDLE) && (state_r != ST_SEND);
    assign timeout_hit_s  = entry_active_s && !kp.key_valid &&
                            (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter, restarted by any key and held at zero outside an open entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (!entry_active_s || kp.key_valid) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Accumulator steering and the "abandon to IDLE" decision for the current state.
    always_comb begin
        in_field_s  = 1'b0;
        acc_digit_s = 1'b0;
        acc_clear_s = 1'b0;
        go_idle_s   = 1'b0;
        case (state_r)
            ST_PIN, ST_NEWPIN, ST_AMOUNT: in_field_s = 1'b1;
            default:                      in_field_s = 1'b0;
        endcase
        if (in_field_s && kp.key_valid) begin
            acc_digit_s = is_digit(kp.key_code) && !acc_full_s;
            acc_clear_s = (kp.key_code == KEY_CLEAR) || (kp.key_code == KEY_CANCEL) ||
                          ((kp.key_code == KEY_ENTER) && (acc_count_s != {CNT_W{1'b0}}));
        end else begin
            acc_digit_s = 1'b0;
            acc_clear_s = in_field_s && timeout_hit_s;
        end
        if (state_r == ST_SEND) begin
            go_idle_s = kp.txn_ready;
        end else if (state_r == ST_IDLE) begin
            go_idle_s = 1'b0;
        end else begin
            go_idle_s = timeout_hit_s || (kp.key_valid && (kp.key_code == KEY_CANCEL));
        end
    end

    // Entry FSM with all transaction fields and status pulses registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            lang_r       <= 1'b0;
            acc_num_r    <= 4'd0;
            acc_loaded_r <= 1'b0;
            pin_r        <= {FIELD_W{1'b0}};
            new_pin_r    <= {FIELD_W{1'b0}};
            amount_r     <= {FIELD_W{1'b0}};
            op_r         <= OP_NONE;
            txn_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
            timeout_r    <= 1'b0;
        end else if (go_idle_s) begin
            // SEND acceptance drops any coincident key; CANCEL/timeout abandon the entry.
            state_r      <= ST_IDLE;
            lang_r       <= 1'b0;
            acc_num_r    <= 4'd0;
            acc_loaded_r <= 1'b0;
            pin_r        <= {FIELD_W{1'b0}};
            new_pin_r    <= {FIELD_W{1'b0}};
            amount_r     <= {FIELD_W{1'b0}};
            op_r         <= OP_NONE;
            txn_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
            timeout_r    <= timeout_hit_s;
        end else begin
            error_r   <= 1'b0;
            timeout_r <= 1'b0;
            if (kp.key_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        if (kp.key_code == KEY_ENTER) begin
                            state_r <= ST_LANG;
                            busy_r  <= 1'b1;
                        end
                    end
                    ST_LANG: begin
                        if (is_digit(kp.key_code)) begin
                            if (kp.key_code <= 4'd1) begin
                                lang_r  <= kp.key_code[0];
                                state_r <= ST_ACC;
                            end else begin
                                error_r <= 1'b1;
                            end
                        end else if (kp.key_code == KEY_CLEAR) begin
                            lang_r <= 1'b0;
                        end else if (kp.key_code == KEY_ENTER) begin
                            error_r <= 1'b1;
                        end
                    end
                    ST_ACC: begin
                        if (is_digit(kp.key_code)) begin
                            acc_num_r    <= kp.key_code;
                            acc_loaded_r <= 1'b1;
                        end else if (kp.key_code == KEY_CLEAR) begin
                            acc_num_r    <= 4'd0;
                            acc_loaded_r <= 1'b0;
                        end else if (kp.key_code == KEY_ENTER) begin
                            if (acc_loaded_r) begin
                                state_r <= ST_PIN;
                            end else begin
                                error_r <= 1'b1;
                            end
                        end
                    end
                    ST_OP: begin
                        if (is_digit(kp.key_code) || (kp.key_code == KEY_ENTER)) begin
                            case (kp.key_code)
                                4'd1: begin
                                    op_r        <= OP_BALANCE;
                                    state_r     <= ST_SEND;
                                    txn_valid_r <= 1'b1;
                                end
                                4'd2: begin
                                    op_r    <= OP_WITHDRAW;
                                    state_r <= ST_AMOUNT;
                                end
                                4'd3: begin
                                    op_r    <= OP_DEPOSIT;
                                    state_r <= ST_AMOUNT;
                                end
                                4'd4: begin
                                    op_r    <= OP_CHANGE_PIN;
                                    state_r <= ST_NEWPIN;
                                end
                                default: error_r <= 1'b1;
                            endcase
                        end
                    end
                    ST_PIN, ST_NEWPIN, ST_AMOUNT: begin
                        if (is_digit(kp.key_code)) begin
                            if (acc_full_s) begin
                                error_r <= 1'b1;
                            end else begin
                                case (state_r)
                                    ST_PIN:    pin_r     <= acc_next_s;
                                    ST_NEWPIN: new_pin_r <= acc_next_s;
                                    default:   amount_r  <= acc_next_s;
                                endcase
                            end
                        end else if (kp.key_code == KEY_CLEAR) begin
                            case (state_r)
                                ST_PIN:    pin_r     <= {FIELD_W{1'b0}};
                                ST_NEWPIN: new_pin_r <= {FIELD_W{1'b0}};
                                default:   amount_r  <= {FIELD_W{1'b0}};
                            endcase
                        end else if (kp.key_code == KEY_ENTER) begin
                            if (acc_count_s == {CNT_W{1'b0}}) begin
                                error_r <= 1'b1;
                            end else if (state_r == ST_PIN) begin
                                state_r <= ST_OP;
                            end else begin
                                state_r     <= ST_SEND;
                                txn_valid_r <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign kp.txn_valid = txn_valid_r;
    assign kp.acc_num   = acc_num_r;
    assign kp.pin       = pin_r;
    assign kp.new_pin   = new_pin_r;
    assign kp.amount    = amount_r;
    assign kp.operation = op_r;
    assign kp.language  = lang_r;
    assign kp.state     = state_r;
    assign kp.busy      = busy_r;
    assign kp.error     = error_r;
    assign kp.timeout   = timeout_r;

endmodule
